// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
//   - Detects load-use hazards between the load in EX and the instruction in ID.
//   - Detects control redirects (taken branch / jump resolved in EX).
//   - Sequences the iterative multiply/divide unit (IDLE/BUSY with a
//     down-counter) and stalls any mfhi/mflo in ID until HI/LO is written.
//   - Keeps a saturating 16-bit count of stalled cycles.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt        source register fields of the ID instruction
//   id_uses_rs/_rt      ID instruction actually reads rs / rt
//   id_reads_hilo       ID instruction is mfhi/mflo
//   id_ex_dm_r          EX instruction is a load
//   id_ex_rt            destination register of the EX load
//   ex_branch_taken     EX resolved a taken branch
//   ex_jump             EX holds a jump/jr/jal
//   md_start            one-cycle issue pulse for mult/div
//   md_is_div           qualifies md_start: 1 = divide, 0 = multiply
//   pc_write            PC write-enable (combinational)
//   if_id_write         IF/ID write-enable (combinational)
//   if_id_flush         IF/ID flush (combinational)
//   id_ex_flush         ID/EX flush, 1 = bubble (combinational)
//   md_busy             multiply/divide in progress (registered)
//   md_done             final busy cycle, HI/LO written at its closing edge
//   md_overlap_err      sticky: md_start seen while busy
//   stall_cycles        saturating stalled-cycle counter
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_reads_hilo,
    input  logic        id_ex_dm_r,
    input  logic [4:0]  id_ex_rt,
    input  logic        ex_branch_taken,
    input  logic        ex_jump,
    input  logic        md_start,
    input  logic        md_is_div,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_overlap_err,
    output logic [15:0] stall_cycles
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Counter reload values: the load cycle itself is not counted, so the
    // unit is busy for exactly N cycles ending with cnt == 0.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overlap_q, overlap_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic busy;
    logic cnt_zero;
    logic rs_match;
    logic rt_match;
    logic load_use;
    logic hilo_stall;
    logic stall;
    logic redirect;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign busy     = (state_q == ST_BUSY);
    assign cnt_zero = (cnt_q == '0);

    assign rs_match = id_uses_rs && (id_rs == id_ex_rt);
    assign rt_match = id_uses_rt && (id_rt == id_ex_rt);

    // $zero is never a real dependency, so a load into r0 never stalls.
    assign load_use = id_ex_dm_r && (id_ex_rt != 5'd0) && (rs_match || rt_match);

    // Covers the issue cycle too: the reader must not slip past a mult/div
    // that is being issued in the same cycle.
    assign hilo_stall = id_reads_hilo && (md_start || busy);

    assign stall    = load_use || hilo_stall;
    assign redirect = ex_branch_taken || ex_jump;

    // ------------------------------------------------------------------
    // Pipeline control decode
    // ------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (redirect) begin
            // The stalled ID instruction is on the wrong path; squash it.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overlap_d = overlap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    state_d = ST_BUSY;
                    cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_BUSY: begin
                // A second issue is never queued or restarted; only flagged.
                if (md_start) begin
                    overlap_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall counter next state (counts only stalls not overridden)
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !redirect && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            overlap_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            overlap_q   <= overlap_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered status outputs
    // ------------------------------------------------------------------
    assign md_busy        = busy;
    assign md_done        = busy && cnt_zero;
    assign md_overlap_err = overlap_q;
    assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam logic [3:0] CTL_RUN   = 4'b1100;
    localparam logic [3:0] CTL_STALL = 4'b0001;
    localparam logic [3:0] CTL_REDIR = 4'b1111;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, id_ex_rt;
    logic        id_uses_rs, id_uses_rt, id_reads_hilo, id_ex_dm_r;
    logic        ex_branch_taken, ex_jump, md_start, md_is_div;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic        md_busy, md_done, md_overlap_err;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .id_reads_hilo(id_reads_hilo),
        .id_ex_dm_r(id_ex_dm_r),
        .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .ex_jump(ex_jump),
        .md_start(md_start),
        .md_is_div(md_is_div),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .md_busy(md_busy),
        .md_done(md_done),
        .md_overlap_err(md_overlap_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] ctl;
        logic       busy;
        logic       done;
    } sb_t;

    sb_t sbq[$];

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       hilo;
        logic       dmr;
        logic [4:0] exrt;
        logic       br;
        logic       jmp;
        logic [3:0] exp_ctl;
    } vec_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; id_ex_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_ex_dm_r = 0;
        ex_branch_taken = 0; ex_jump = 0; md_start = 0; md_is_div = 0;
    endtask

    // Inputs are already driven; record expectation, compare at negedge,
    // then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic [3:0] ctl, input logic busy,
                       input logic done);
        sb_t e;
        sbq.push_back('{nm, ctl, busy, done});
        @(negedge clk);
        e = sbq.pop_front();
        cmp(e.name, {26'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done},
            {26'd0, e.ctl, e.busy, e.done});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        int   exp_cnt;

        clr_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // ---- reset state ----
        cyc("reset_ctl", CTL_RUN, 1'b0, 1'b0);
        cmp("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        cmp("reset_overlap", 32'(md_overlap_err), 32'd0);
        reset = 1'b0;

        // ---- table-driven decode, state IDLE ----
        vecs[0]  = '{5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 0, CTL_RUN};
        vecs[1]  = '{5'd5,  5'd0,  1, 0, 0, 1, 5'd5,  0, 0, CTL_STALL};
        vecs[2]  = '{5'd0,  5'd0,  1, 0, 0, 1, 5'd0,  0, 0, CTL_RUN};
        vecs[3]  = '{5'd1,  5'd7,  0, 1, 0, 1, 5'd7,  0, 0, CTL_STALL};
        vecs[4]  = '{5'd1,  5'd7,  0, 0, 0, 1, 5'd7,  0, 0, CTL_RUN};
        vecs[5]  = '{5'd7,  5'd3,  0, 1, 0, 1, 5'd7,  0, 0, CTL_RUN};
        vecs[6]  = '{5'd5,  5'd0,  1, 0, 0, 0, 5'd5,  0, 0, CTL_RUN};
        vecs[7]  = '{5'd5,  5'd0,  1, 0, 0, 1, 5'd5,  1, 0, CTL_REDIR};
        vecs[8]  = '{5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 1, CTL_REDIR};
        vecs[9]  = '{5'd0,  5'd0,  0, 0, 1, 0, 5'd0,  0, 0, CTL_RUN};
        vecs[10] = '{5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  1, 1, CTL_REDIR};
        vecs[11] = '{5'd31, 5'd31, 1, 1, 0, 1, 5'd31, 0, 0, CTL_STALL};
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            clr_in();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            id_reads_hilo = vecs[i].hilo; id_ex_dm_r = vecs[i].dmr;
            id_ex_rt = vecs[i].exrt; ex_branch_taken = vecs[i].br; ex_jump = vecs[i].jmp;
            if (vecs[i].exp_ctl == CTL_STALL) exp_cnt++;
            cyc($sformatf("vec%0d", i), vecs[i].exp_ctl, 1'b0, 1'b0);
        end
        cmp("vec_stall_cycles", 32'(stall_cycles), 32'(exp_cnt));

        // ---- load-use: single stall, clears when load leaves EX ----
        do_reset();
        id_ex_dm_r = 1; id_ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
        cyc("lu_stall", CTL_STALL, 1'b0, 1'b0);
        clr_in();
        cyc("lu_release", CTL_RUN, 1'b0, 1'b0);
        cmp("lu_stall_cycles", 32'(stall_cycles), 32'd1);

        // ---- multiply then mfhi ----
        do_reset();
        md_start = 1; md_is_div = 0; id_reads_hilo = 1;
        cyc("mul_c0", CTL_STALL, 1'b0, 1'b0);
        md_start = 0;
        for (int c = 1; c <= 4; c++) begin
            cyc($sformatf("mul_c%0d", c), CTL_STALL, 1'b1, (c == 4));
        end
        cyc("mul_c5", CTL_RUN, 1'b0, 1'b0);
        cmp("mul_stall_cycles", 32'(stall_cycles), 32'd5);

        // ---- redirect over stall, and during divide ----
        do_reset();
        id_ex_dm_r = 1; id_ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1; ex_branch_taken = 1;
        cyc("redir_over_stall", CTL_REDIR, 1'b0, 1'b0);
        cmp("redir_stall_cycles", 32'(stall_cycles), 32'd0);
        clr_in();
        md_start = 1; md_is_div = 1;
        cyc("div_c0", CTL_RUN, 1'b0, 1'b0);
        clr_in();
        for (int c = 1; c <= 33; c++) begin
            ex_jump = (c == 3);
            cyc($sformatf("div_c%0d", c), (c == 3) ? CTL_REDIR : CTL_RUN, (c <= 32),
                (c == 32));
        end
        clr_in();

        // ---- overlap mid-multiply, then accepted restart ----
        do_reset();
        md_start = 1;
        cyc("ovl_c0", CTL_RUN, 1'b0, 1'b0);
        md_start = 0;
        cyc("ovl_c1", CTL_RUN, 1'b1, 1'b0);
        cmp("ovl_before", 32'(md_overlap_err), 32'd0);
        md_start = 1;
        cyc("ovl_c2", CTL_RUN, 1'b1, 1'b0);
        md_start = 0;
        cmp("ovl_set", 32'(md_overlap_err), 32'd1);
        cyc("ovl_c3", CTL_RUN, 1'b1, 1'b0);
        cyc("ovl_c4", CTL_RUN, 1'b1, 1'b1);
        md_start = 1;
        cyc("ovl_c5", CTL_RUN, 1'b0, 1'b0);
        md_start = 0;
        for (int c = 6; c <= 10; c++) begin
            cyc($sformatf("ovl_c%0d", c), CTL_RUN, (c <= 9), (c == 9));
        end
        cmp("ovl_sticky", 32'(md_overlap_err), 32'd1);

        // ---- start on the done cycle is an overlap and is not accepted ----
        do_reset();
        cmp("ovl2_cleared", 32'(md_overlap_err), 32'd0);
        md_start = 1;
        cyc("ovl2_c0", CTL_RUN, 1'b0, 1'b0);
        md_start = 0;
        for (int c = 1; c <= 3; c++) cyc($sformatf("ovl2_c%0d", c), CTL_RUN, 1'b1, 1'b0);
        md_start = 1;
        cyc("ovl2_c4", CTL_RUN, 1'b1, 1'b1);
        md_start = 0;
        cyc("ovl2_c5", CTL_RUN, 1'b0, 1'b0);
        cmp("ovl2_err", 32'(md_overlap_err), 32'd1);

        // ---- reset mid-divide (cnt = 10 at cycle 22) ----
        do_reset();
        md_start = 1; md_is_div = 1;
        cyc("rdiv_c0", CTL_RUN, 1'b0, 1'b0);
        clr_in();
        for (int c = 1; c <= 21; c++) cyc($sformatf("rdiv_c%0d", c), CTL_RUN, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        cmp("rdiv_busy_async", 32'(md_busy), 32'd0);
        cmp("rdiv_done_async", 32'(md_done), 32'd0);
        cyc("rdiv_hold", CTL_RUN, 1'b0, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) cyc($sformatf("rdiv_post%0d", c), CTL_RUN, 1'b0, 1'b0);
        cmp("rdiv_stall_cycles", 32'(stall_cycles), 32'd0);

        // ---- saturation: back-to-back divides with mfhi held in ID ----
        do_reset();
        id_reads_hilo = 1; md_is_div = 1;
        exp_cnt = 0;
        for (int d = 0; d < 1990; d++) begin
            for (int c = 0; c <= 32; c++) begin
                md_start = (c == 0);
                @(posedge clk);
                #1;
                if (exp_cnt != 65535) exp_cnt++;
            end
            if (d == 999) cmp("sat_mid", 32'(stall_cycles), 32'(exp_cnt));
        end
        md_start = 0;
        cmp("sat_model", 32'(exp_cnt), 32'd65535);
        cmp("sat_hold", 32'(stall_cycles), 32'hFFFF);
        cyc("sat_release", CTL_RUN, 1'b0, 1'b0);
        cmp("sat_after", 32'(stall_cycles), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
